pipeline_ctrl_regs: RTL

// Pipelined successor of the single-cycle MIPS control decoder. Decodes the ID-stage opcode into
// the control bundle and carries it, with register specifiers, through ID/EX, EX/MEM and MEM/WB.

---
 rtl/pipeline_ctrl_regs.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/pipeline_ctrl_regs.sv
// ============================================================================
// Module   : pipeline_ctrl_regs
// Brief    : Pipelined MIPS control: ID decode, ID/EX-EX/MEM-MEM/WB control
//            registers, load-use stall and branch/jump flush generation.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipeline_ctrl_regs #(
   parameter int OPW     = 6,
   parameter int RAW     = 5,
   parameter int EXT_OPS = 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [OPW-1:0] id_opcode,
   input  logic [RAW-1:0] id_rs,
   input  logic [RAW-1:0] id_rt,
   input  logic [RAW-1:0] id_rd,
   input  logic           br_taken,
   output logic           stall,
   output logic           flush_ifid,
   output logic           ex_regdst,
   output logic           ex_alusrc,
   output logic [1:0]     ex_aluop,
   output logic           ex_branch,
   output logic [RAW-1:0] ex_rs,
   output logic [RAW-1:0] ex_rt,
   output logic [RAW-1:0] ex_rd,
   output logic           mem_memread,
   output logic           mem_memwrite,
   output logic [RAW-1:0] mem_dst,
   output logic           wb_regwrite,
   output logic           wb_memtoreg,
   output logic [RAW-1:0] wb_dst,
   output logic           illegal_op
);

   localparam logic [OPW-1:0] c_op_r    = OPW'(6'b000000);
   localparam logic [OPW-1:0] c_op_lw   = OPW'(6'b100011);
   localparam logic [OPW-1:0] c_op_sw   = OPW'(6'b101011);
   localparam logic [OPW-1:0] c_op_beq  = OPW'(6'b000100);
   localparam logic [OPW-1:0] c_op_j    = OPW'(6'b000010);
   localparam logic [OPW-1:0] c_op_addi = OPW'(6'b001000);

   logic       w_regdst, w_alusrc, w_branch, w_memread, w_memwrite;
   logic       w_regwrite, w_memtoreg, w_jump, w_illegal, w_hz;
   logic [1:0] w_aluop;

   logic           r_ex_regdst, r_ex_alusrc, r_ex_branch, r_ex_memread;
   logic           r_ex_memwrite, r_ex_regwrite, r_ex_memtoreg, r_ex_illegal;
   logic [1:0]     r_ex_aluop;
   logic [RAW-1:0] r_ex_rs, r_ex_rt, r_ex_rd;
   logic           r_mem_memread, r_mem_memwrite, r_mem_regwrite, r_mem_memtoreg;
   logic [RAW-1:0] r_mem_dst;
   logic           r_wb_regwrite, r_wb_memtoreg;
   logic [RAW-1:0] r_wb_dst;

   always_comb begin
      w_regdst   = 1'b0;
      w_alusrc   = 1'b0;
      w_branch   = 1'b0;
      w_memread  = 1'b0;
      w_memwrite = 1'b0;
      w_regwrite = 1'b0;
      w_memtoreg = 1'b0;
      w_jump     = 1'b0;
      w_illegal  = 1'b0;
      w_aluop    = 2'b00;
      case (id_opcode)
         c_op_r: begin
            w_regdst   = 1'b1;
            w_regwrite = 1'b1;
            w_aluop    = 2'b10;
         end
         c_op_lw: begin
            w_alusrc   = 1'b1;
            w_memtoreg = 1'b1;
            w_regwrite = 1'b1;
            w_memread  = 1'b1;
         end
         c_op_sw: begin
            w_alusrc   = 1'b1;
            w_memwrite = 1'b1;
         end
         c_op_beq: begin
            w_branch = 1'b1;
            w_aluop  = 2'b01;
         end
         c_op_j: w_jump = 1'b1;
         c_op_addi: begin
            if (EXT_OPS != 0) begin
               w_alusrc   = 1'b1;
               w_regwrite = 1'b1;
            end else begin
               w_illegal = 1'b1;
            end
         end
         default: w_illegal = 1'b1;
      endcase
   end

   // Register 0 is hardwired, so a load targeting it can never create a hazard.
   assign w_hz       = r_ex_memread && (r_ex_rt != '0) &&
                       ((r_ex_rt == id_rs) || (r_ex_rt == id_rt));
   assign stall      = w_hz & ~br_taken;
   assign flush_ifid = br_taken | (w_jump & ~stall);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ex_regdst   <= 1'b0;
         r_ex_alusrc   <= 1'b0;
         r_ex_aluop    <= 2'b00;
         r_ex_branch   <= 1'b0;
         r_ex_memread  <= 1'b0;
         r_ex_memwrite <= 1'b0;
         r_ex_regwrite <= 1'b0;
         r_ex_memtoreg <= 1'b0;
         r_ex_illegal  <= 1'b0;
         r_ex_rs       <= '0;
         r_ex_rt       <= '0;
         r_ex_rd       <= '0;
      end else if (br_taken || w_hz) begin
         r_ex_regdst   <= 1'b0;
         r_ex_alusrc   <= 1'b0;
         r_ex_aluop    <= 2'b00;
         r_ex_branch   <= 1'b0;
         r_ex_memread  <= 1'b0;
         r_ex_memwrite <= 1'b0;
         r_ex_regwrite <= 1'b0;
         r_ex_memtoreg <= 1'b0;
         r_ex_illegal  <= 1'b0;
         r_ex_rs       <= '0;
         r_ex_rt       <= '0;
         r_ex_rd       <= '0;
      end else begin
         // Jumps and illegal opcodes become bubbles but still carry specifiers.
         r_ex_regdst   <= w_regdst;
         r_ex_alusrc   <= w_alusrc;
         r_ex_aluop    <= w_aluop;
         r_ex_branch   <= w_branch;
         r_ex_memread  <= w_memread;
         r_ex_memwrite <= w_memwrite;
         r_ex_regwrite <= w_regwrite;
         r_ex_memtoreg <= w_memtoreg;
         r_ex_illegal  <= w_illegal;
         r_ex_rs       <= id_rs;
         r_ex_rt       <= id_rt;
         r_ex_rd       <= id_rd;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mem_memread  <= 1'b0;
         r_mem_memwrite <= 1'b0;
         r_mem_regwrite <= 1'b0;
         r_mem_memtoreg <= 1'b0;
         r_mem_dst      <= '0;
         r_wb_regwrite  <= 1'b0;
         r_wb_memtoreg  <= 1'b0;
         r_wb_dst       <= '0;
      end else begin
         r_mem_memread  <= r_ex_memread;
         r_mem_memwrite <= r_ex_memwrite;
         r_mem_regwrite <= r_ex_regwrite;
         r_mem_memtoreg <= r_ex_memtoreg;
         r_mem_dst      <= r_ex_regdst ? r_ex_rd : r_ex_rt;
         r_wb_regwrite  <= r_mem_regwrite;
         r_wb_memtoreg  <= r_mem_memtoreg;
         r_wb_dst       <= r_mem_dst;
      end
   end

   assign ex_regdst    = r_ex_regdst;
   assign ex_alusrc    = r_ex_alusrc;
   assign ex_aluop     = r_ex_aluop;
   assign ex_branch    = r_ex_branch;
   assign ex_rs        = r_ex_rs;
   assign ex_rt        = r_ex_rt;
   assign ex_rd        = r_ex_rd;
   assign illegal_op   = r_ex_illegal;
   assign mem_memread  = r_mem_memread;
   assign mem_memwrite = r_mem_memwrite;
   assign mem_dst      = r_mem_dst;
   assign wb_regwrite  = r_wb_regwrite;
   assign wb_memtoreg  = r_wb_memtoreg;
   assign wb_dst       = r_wb_dst;

endmodule

`default_nettype wire
